edge_pair_gen: RTL
==================

# edge_pair_gen

Programmable reference/generated edge-pair source: from `fpga_clk_i` it produces two square waves, `ref_o` and `gen_o`, with a commanded signed phase offset in fpga-clock cycles. It is the transmitting counterpart of the network phase detectors. It drives `ref_left_i`/`ref_above_i` of boundary ring nodes and provides known-offset stimulus for phase-detector calibration. Offset and period updates arrive over a valid/ready handshake and take effect glitch-free at period boundaries.

## Interface
- `PDET_WIDTH`, 5: width of the signed offset; matches the phase-detector error width.
- `HALF_WIDTH`, 6: width of the half-period field.
- `DEFAULT_HALF`, 16: half-period, in fpga cycles, loaded at reset.
- `fpga_clk_i`  in  1  sole clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  run when high; outputs forced low when low.
- `half_i`  in  HALF_WIDTH  requested half-period in cycles; 0 is treated as 1.
- `offset_i`  in  PDET_WIDTH signed  requested lag of `gen_o` behind `ref_o`, in cycles; negative means `gen_o` leads.
- `cfg_valid_i`  in  1  a request is present on `half_i`/`offset_i`.
- `cfg_ready_o`  out  1  the shadow register is free.
- `ref_o`  out  1  reference square wave.
- `gen_o`  out  1  phase-offset square wave.
- `wrap_o`  out  1  one-cycle pulse on the cycle `ref_o` rises.

## Operation
- FSM states:
  - IDLE: `enable_i` low. Outputs are 0.
  - RUN: counting, no update pending.
  - PEND: counting, with a captured update waiting for the next wrap.
- Counter `cnt` is HALF_WIDTH+1 bits. It runs 0..P-1, where P = 2·H and H is the active half-period.
- `ref_o` = (`cnt` < H).
- `gen_o` = (idx < H), where idx = (`cnt` − off) mod P. Compute as: if negative, add P; if ≥ P, subtract P.
- Active offset clamping: offset is clamped to ±(H−1) at application time.
- Handshake:
  - A transfer occurs when `cfg_valid_i` and `cfg_ready_o` are both high. `half_i`/`offset_i` are captured into the shadow.
  - `cfg_ready_o` is low while in PEND.
  - A transfer in RUN moves the FSM to PEND.
  - In IDLE, the shadow is applied on the following cycle and the FSM stays in IDLE. `cfg_ready_o` stays high.
- Application: in PEND, on the cycle `cnt` goes from P−1 to 0, the shadow H and offset become active and the FSM returns to RUN. `cfg_ready_o` rises one cycle later.
- IDLE→RUN: when `enable_i` is sampled high, `cnt` loads 0 and `ref_o` rises on that same edge.
- RUN/PEND→IDLE: when `enable_i` is sampled low, `cnt`, `ref_o`, `gen_o` and `wrap_o` clear.
  - A pending shadow is applied immediately and `cfg_ready_o` returns high.
- Simultaneous wrap and transfer in RUN: the new request is captured. It applies at the following wrap, not the current one.
- Because of the clamp, offset = ±H yields ±(H−1). Half-period 0 yields H = 1; the offset is then clamped to 0.

## Timing
- Reset values: `ref_o`=0, `gen_o`=0, `wrap_o`=0, `cfg_ready_o`=1, state IDLE, `cnt`=0, active H = DEFAULT_HALF, active offset 0, shadow cleared.
- All outputs are registered. Zero cycles from the counter state to the outputs; the same edge updates both.
- `ref_o` period is exactly 2H cycles with a 50% duty cycle. `gen_o` has the same period and edge spacing.
- Latency from request acceptance to effect:
  - in RUN: at most P cycles (next wrap);
  - in IDLE: 1 cycle.
- Reset asserted mid-operation clears everything asynchronously. It does not wait for a wrap.

## Configuration
- `EDGE_GEN_SWEEP_EN`:
  - Adds input `sweep_i` (1 bit).
  - While `sweep_i` is high in RUN, each wrap increments the active offset by 1. +(H−1) wraps to −(H−1).
  - A shadow application at the same wrap takes priority over the sweep step. No sweep step occurs in PEND.
- Without the macro: the port is absent and the offset changes only through the handshake.

## Structure
- Package `edge_gen_pkg`: FSM state enum {IDLE, RUN, PEND}, the offset/count width localparams, and the offset clamp function.
- One sub-module, `edge_gen_phase_calc`: combinational modular index (`cnt` − off mod P) and the `gen_o` compare. It is reused for both outputs with offset 0 for `ref_o`.

## Test plan
- Reset, enable with DEFAULT_HALF=16, offset 0 → `ref_o` = `gen_o`, period 32 cycles, `wrap_o` every 32 cycles, first `ref_o` rise on the enable edge.
- In IDLE, transfer H=8, offset +3, then enable → `gen_o` rises 3 cycles after each `ref_o` rise; period 16.
- In RUN (H=8), transfer offset −5 mid-period → `cfg_ready_o` low until the next wrap; from that wrap `gen_o` leads by 5; `cfg_ready_o` high 1 cycle later.
- Offset +15 with H=4 → clamped to +3. `half_i`=0 → period 2, `gen_o` = `ref_o`.
- Reset asserted during PEND → all outputs 0 immediately, `cfg_ready_o`=1, H=16 restored.
- With `EDGE_GEN_SWEEP_EN`, H=4, `sweep_i` high → offsets over successive periods −3,−2,…,+3,−3. A transfer at a wrap overrides that step.

Source files
------------

// File: rtl/edge_gen_pkg.sv
// Shared types, default widths and the offset clamp helper for the edge-pair generator.
package edge_gen_pkg;

  localparam int unsigned PdetWidth = 5;
  localparam int unsigned HalfWidth = 6;
  localparam int unsigned CntWidth  = HalfWidth + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPend
  } edge_state_e;

  // Limits an offset to +/-(half-1) so gen_o always stays within one period of ref_o.
  function automatic int clamp_offset(int off, int half);
    int lim;
    lim = half - 1;
    if (off > lim) return lim;
    if (off < -lim) return -lim;
    return off;
  endfunction

endpackage

// File: rtl/edge_gen_phase_calc.sv
// Combinational phase compare: high when (cnt - off) mod 2*half falls in the first half-period.
module edge_gen_phase_calc #(
  parameter int unsigned CntWidth = 7,
  parameter int unsigned OffWidth = 5
) (
  input  logic [CntWidth-1:0]        cnt_i,
  input  logic [CntWidth-2:0]        half_i,
  input  logic signed [OffWidth-1:0] off_i,
  output logic                       high_o
);

  localparam int unsigned SW = CntWidth + OffWidth + 1;

  logic signed [SW-1:0] cnt_s, off_s, per_s, half_s, diff_s, idx_s;

  // |off| < half keeps the difference within one period of [0, P), so one correction suffices.
  always_comb begin
    cnt_s  = SW'(cnt_i);
    off_s  = SW'(off_i);
    per_s  = SW'({half_i, 1'b0});
    half_s = SW'(half_i);
    diff_s = cnt_s - off_s;
    if (diff_s[SW-1]) begin
      idx_s = diff_s + per_s;
    end else if (diff_s >= per_s) begin
      idx_s = diff_s - per_s;
    end else begin
      idx_s = diff_s;
    end
    high_o = idx_s < half_s;
  end

endmodule

// File: rtl/edge_pair_gen.sv
// Reference/generated square-wave pair with programmable signed phase offset.
// Optional EDGE_GEN_SWEEP_EN adds sweep_i, stepping the offset once per period.
module edge_pair_gen
  import edge_gen_pkg::*;
#(
  parameter int unsigned PDET_WIDTH   = PdetWidth,
  parameter int unsigned HALF_WIDTH   = HalfWidth,
  parameter int unsigned DEFAULT_HALF = 16
) (
  input  logic                         fpga_clk_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic [HALF_WIDTH-1:0]        half_i,
  input  logic signed [PDET_WIDTH-1:0] offset_i,
  input  logic                         cfg_valid_i,
`ifdef EDGE_GEN_SWEEP_EN
  input  logic                         sweep_i,
`endif
  output logic                         cfg_ready_o,
  output logic                         ref_o,
  output logic                         gen_o,
  output logic                         wrap_o
);

  localparam int unsigned CW = HALF_WIDTH + 1;

  edge_state_e                  state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [HALF_WIDTH-1:0]        half_q, half_d, sh_half_q, sh_half_d, sh_h_eff;
  logic signed [PDET_WIDTH-1:0] off_q, off_d, sh_off_q, sh_off_d, sh_off_eff;
  logic                         idle_apply_q, idle_apply_d;
  logic                         ready_q, ready_d;
  logic                         ref_q, ref_d, gen_q, gen_d, wrap_q, wrap_d;
  logic                         xfer, at_end, run, ref_hi, gen_hi;

  assign xfer       = cfg_valid_i & ready_q;
  assign at_end     = (cnt_q == ({half_q, 1'b0} - CW'(1)));
  assign sh_h_eff   = (sh_half_q == '0) ? HALF_WIDTH'(1) : sh_half_q;
  assign sh_off_eff = PDET_WIDTH'(clamp_offset(int'(sh_off_q), int'(sh_h_eff)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    off_d        = off_q;
    sh_half_d    = sh_half_q;
    sh_off_d     = sh_off_q;
    idle_apply_d = 1'b0;
    ready_d      = ready_q;
    wrap_d       = 1'b0;
    run          = 1'b0;
    if (xfer) begin
      sh_half_d = half_i;
      sh_off_d  = offset_i;
    end
    unique case (state_q)
      StIdle: begin
        if (idle_apply_q) begin
          half_d = sh_h_eff;
          off_d  = sh_off_eff;
        end
        cnt_d   = '0;
        ready_d = 1'b1;
        if (enable_i) begin
          run    = 1'b1;
          wrap_d = 1'b1;
          // A request accepted on the start edge waits for the first wrap.
          if (xfer) begin
            state_d = StPend;
            ready_d = 1'b0;
          end else begin
            state_d = StRun;
          end
        end else begin
          idle_apply_d = xfer;
        end
      end
      StRun, StPend: begin
        if (!enable_i) begin
          state_d      = StIdle;
          cnt_d        = '0;
          ready_d      = 1'b1;
          idle_apply_d = xfer;
          if (state_q == StPend) begin
            half_d = sh_h_eff;
            off_d  = sh_off_eff;
          end
        end else begin
          run    = 1'b1;
          cnt_d  = at_end ? '0 : cnt_q + CW'(1);
          wrap_d = at_end;
          if (state_q == StPend) begin
            ready_d = 1'b0;
            if (at_end) begin
              half_d  = sh_h_eff;
              off_d   = sh_off_eff;
              state_d = StRun;
            end
          end else begin
            ready_d = !xfer;
            if (xfer) state_d = StPend;
`ifdef EDGE_GEN_SWEEP_EN
            if (sweep_i && at_end) begin
              off_d = (int'(off_q) >= int'(half_q) - 1) ? PDET_WIDTH'(1 - int'(half_q))
                                                         : off_q + PDET_WIDTH'(1);
            end
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Both outputs see the next counter and next active config, so they land on the same edge.
  edge_gen_phase_calc #(
    .CntWidth(CW),
    .OffWidth(PDET_WIDTH)
  ) u_ref_calc (
    .cnt_i (cnt_d),
    .half_i(half_d),
    .off_i ('0),
    .high_o(ref_hi)
  );

  edge_gen_phase_calc #(
    .CntWidth(CW),
    .OffWidth(PDET_WIDTH)
  ) u_gen_calc (
    .cnt_i (cnt_d),
    .half_i(half_d),
    .off_i (off_d),
    .high_o(gen_hi)
  );

  assign ref_d = run & ref_hi;
  assign gen_d = run & gen_hi;

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      half_q       <= HALF_WIDTH'(DEFAULT_HALF);
      off_q        <= '0;
      sh_half_q    <= '0;
      sh_off_q     <= '0;
      idle_apply_q <= 1'b0;
      ready_q      <= 1'b1;
      ref_q        <= 1'b0;
      gen_q        <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      off_q        <= off_d;
      sh_half_q    <= sh_half_d;
      sh_off_q     <= sh_off_d;
      idle_apply_q <= idle_apply_d;
      ready_q      <= ready_d;
      ref_q        <= ref_d;
      gen_q        <= gen_d;
      wrap_q       <= wrap_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign ref_o       = ref_q;
  assign gen_o       = gen_q;
  assign wrap_o      = wrap_q;

endmodule
